// File: rtl/avalon_ddr_port_arbiter_if.sv
// Avalon-MM burst port bundle; used for both requester ports and the controller side.
interface avalon_ddr_port_arbiter_if #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 128
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic              write;
  logic              burstbegin;
  logic [7:0]        size;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  // Command issuer: drives commands, receives stalls and return data.
  modport master (
    output address, writedata, read, write, burstbegin, size,
    input  waitrequest, readdatavalid, readdata
  );

  // Command receiver: accepts commands, returns stalls and data.
  modport slave (
    input  address, writedata, read, write, burstbegin, size,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/avalon_ddr_port_arbiter.sv
// Two-port round-robin, burst-locked arbiter in front of the DDR3 controller
// Avalon-MM port, with an in-order tag FIFO steering read returns.
module avalon_ddr_port_arbiter #(
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                       iCLK,
  input  logic                       iRST_n,
  avalon_ddr_port_arbiter_if.slave   m0,
  avalon_ddr_port_arbiter_if.slave   m1,
  avalon_ddr_port_arbiter_if.master  avl,
  output logic [$clog2(TAG_DEPTH):0] rd_outstanding,
  output logic                       arb_error
);

  localparam int unsigned PTR_W  = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SIZE_W = 8;

  typedef enum logic {ARB, XFER} state_t;

  typedef struct packed {
    logic              port;
    logic [SIZE_W-1:0] size;
  } tag_t;

  state_t            state;
  logic              gnt;
  logic              last_gnt;
  logic [SIZE_W-1:0] wbeat;
  logic [SIZE_W-1:0] rbeat;

  tag_t              tags [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] g_address;
  logic [DATA_W-1:0] g_writedata;
  logic              g_read;
  logic              g_write;
  logic              g_burstbegin;
  logic [SIZE_W-1:0] g_size;
  logic [SIZE_W-1:0] g_size_eff;

  logic              in_xfer;
  logic              full;
  logic              empty;
  logic              elig0;
  logic              elig1;
  logic              pick;
  logic              wr_acc;
  logic              rd_acc;
  logic              push;
  logic              pop;
  tag_t              head;

  // Select the granted requester's command signals.
  always_comb begin
    g_address    = m0.address;
    g_writedata  = m0.writedata;
    g_read       = m0.read;
    g_write      = m0.write;
    g_burstbegin = m0.burstbegin;
    g_size       = m0.size;
    if (gnt) begin
      g_address    = m1.address;
      g_writedata  = m1.writedata;
      g_read       = m1.read;
      g_write      = m1.write;
      g_burstbegin = m1.burstbegin;
      g_size       = m1.size;
    end
  end

  // A zero burst length is treated as a single beat.
  assign g_size_eff = (g_size == '0) ? SIZE_W'(1) : g_size;

  assign in_xfer = (state == XFER);
  assign full    = (count == CNT_W'(TAG_DEPTH));
  assign empty   = (count == '0);

  // Reads need a free tag slot; writes never stall on the FIFO.
  assign elig0 = m0.write | (m0.read & ~full);
  assign elig1 = m1.write | (m1.read & ~full);
  assign pick  = (elig0 & elig1) ? ~last_gnt : elig1;

  // Controller command path; write wins when a requester drives both.
  assign avl.address    = in_xfer ? g_address : '0;
  assign avl.writedata  = in_xfer ? g_writedata : '0;
  assign avl.read       = in_xfer & g_read & ~g_write;
  assign avl.write      = in_xfer & g_write;
  assign avl.burstbegin = in_xfer & g_burstbegin;
  assign avl.size       = in_xfer ? g_size : '0;

  assign m0.waitrequest = ~(in_xfer & ~gnt) | avl.waitrequest;
  assign m1.waitrequest = ~(in_xfer &  gnt) | avl.waitrequest;

  assign wr_acc = avl.write & ~avl.waitrequest;
  assign rd_acc = avl.read  & ~avl.waitrequest;

  // Return path: data fans out, valid follows the oldest outstanding tag.
  assign head             = tags[rd_ptr];
  assign push             = rd_acc;
  assign pop              = avl.readdatavalid & ~empty & (rbeat == head.size - SIZE_W'(1));
  assign m0.readdata      = avl.readdata;
  assign m1.readdata      = avl.readdata;
  assign m0.readdatavalid = avl.readdatavalid & ~empty & ~head.port;
  assign m1.readdatavalid = avl.readdatavalid & ~empty &  head.port;
  assign rd_outstanding   = count;

  // Grant FSM: arbitrate, then hold the grant for a write burst or one read command.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= ARB;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      wbeat    <= '0;
    end else if (state == ARB) begin
      if (elig0 | elig1) begin
        gnt   <= pick;
        state <= XFER;
      end
    end else begin
      if (wr_acc) begin
        if (wbeat == g_size_eff - SIZE_W'(1)) begin
          wbeat    <= '0;
          last_gnt <= gnt;
          state    <= ARB;
        end else begin
          wbeat <= wbeat + SIZE_W'(1);
        end
      end else if (rd_acc) begin
        last_gnt <= gnt;
        state    <= ARB;
      end
    end
  end

  // Tag storage; validity is tracked by the pointers and count.
  always_ff @(posedge iCLK) begin
    if (push) begin
      tags[wr_ptr] <= '{port: gnt, size: g_size_eff};
    end
  end

  // Tag FIFO pointers, return beat counter and sticky orphan-return flag.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rbeat     <= '0;
      arb_error <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (avl.readdatavalid) begin
        if (empty) begin
          arb_error <= 1'b1;
        end else if (pop) begin
          rbeat  <= '0;
          rd_ptr <= rd_ptr + PTR_W'(1);
        end else begin
          rbeat <= rbeat + SIZE_W'(1);
        end
      end
      if (push & ~pop) begin
        count <= count + CNT_W'(1);
      end else if (pop & ~push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/avalon_ddr_port_arbiter.md
Name: avalon_ddr_port_arbiter

Overview:
- Shares the single Avalon-MM port of the DDR3 controller between two burst-capable requesters: port 0 (capture writer) and port 1 (host/test reader-writer).
- Round-robin, burst-locked grant.
- Read-return routing through an in-order tag FIFO, so each read beat goes back to the port that issued the read.
- Sits between the requesters and the DDR3 controller local interface, on the controller's user clock.

Parameters:
- ADDR_W, 26: word address width.
- DATA_W, 128: data width.
- TAG_DEPTH, 16: maximum outstanding read commands (power of 2).

Ports:
- iCLK  in  1  controller user clock.
- iRST_n  in  1  asynchronous active-low reset.
- mN_address  in  ADDR_W  requester N address (N = 0, 1 for every mN_ port).
- mN_writedata  in  DATA_W  requester N write data.
- mN_read  in  1  requester N read command.
- mN_write  in  1  requester N write beat.
- mN_burstbegin  in  1  requester N first beat of a burst.
- mN_size  in  8  requester N burst length in beats.
- mN_waitrequest  out  1  stall to requester N, active-high.
- mN_readdatavalid  out  1  return beat valid for requester N.
- mN_readdata  out  DATA_W  return data for requester N.
- avl_address  out  ADDR_W  to controller.
- avl_writedata  out  DATA_W  to controller.
- avl_read  out  1  to controller.
- avl_write  out  1  to controller.
- avl_burstbegin  out  1  to controller.
- avl_size  out  8  to controller.
- avl_waitrequest  in  1  controller stall, active-high.
- avl_readdatavalid  in  1  controller return valid.
- avl_readdata  in  DATA_W  controller return data.
- rd_outstanding  out  log2(TAG_DEPTH)+1  tag FIFO occupancy.
- arb_error  out  1  sticky; set on readdatavalid with empty tag FIFO.

Behaviour:
- Reset (asynchronous, iRST_n low):
  - state=ARB, grant=none, last_grant=1, beat counters=0, tag FIFO empty, arb_error=0.
  - avl_read, avl_write, avl_burstbegin = 0; avl_size=0.
  - mN_waitrequest=1; mN_readdatavalid=0.
  - Reset mid-burst abandons the burst and discards outstanding tags.
- State ARB:
  - A port requests when mN_read or mN_write is high.
  - Read requests are eligible only when the tag FIFO is not full; writes are always eligible.
  - One eligible requester: grant it. Two eligible: grant the port != last_grant.
  - The grant register loads at the clock edge and state moves to XFER. Request-to-first-command latency is 1 cycle.
  - No outputs are driven to the controller while in ARB.
- State XFER:
  - avl_* command outputs are a combinational copy of the granted port's signals.
  - mG_waitrequest = avl_waitrequest for the granted port; the other port's waitrequest is held at 1.
  - A beat is accepted when (avl_read|avl_write) & !avl_waitrequest.
- Write burst:
  - On each accepted write beat, wbeat increments.
  - When wbeat reaches size_eff-1 (size_eff = mG_size, or 1 if mG_size==0), wbeat clears, last_grant=G, and state returns to ARB.
  - The grant holds for the entire burst even if the requester deasserts write mid-burst; the other port waits.
- Read:
  - An accepted read command pushes tag {G, size_eff} and releases immediately: last_grant=G, state returns to ARB.
  - Read and write both asserted on the granted port is illegal; write takes priority and avl_read is forced to 0.
- Per-transaction bubble: exactly one ARB cycle (no controller command) between consecutive transactions.
- Return path:
  - avl_readdata fans out to both mN_readdata.
  - mN_readdatavalid = avl_readdatavalid & (head tag port == N).
  - rbeat counts return beats; after the head tag's size_eff beats the tag pops and rbeat clears.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - avl_readdatavalid with an empty FIFO sets arb_error; the beat is routed to neither port.
- Full FIFO (occupancy == TAG_DEPTH): reads are not granted; pending writes proceed.
- Widths: beat counters and size are 8 bits, unsigned; counters wrap modulo 256, but with size <= 255 they never wrap.

Test Plan:
- Reset, then m0 issues a 4-beat write with controller waitrequest=0 → avl_write high on cycles 2-5, m1_waitrequest=1 throughout, ARB bubble on cycle 6.
- m0 and m1 both request single writes continuously from reset → grants alternate 0,1,0,1; each avl command separated by one idle cycle.
- m1 issues a read of size 4 at address 0x100, then m0 issues a read of size 2; controller returns 6 beats → m1_readdatavalid on the first 4 beats, m0_readdatavalid on the last 2, rd_outstanding goes 1,2,1,0.
- Controller holds avl_waitrequest=1 for 5 cycles mid write burst while m1 requests → grant stays on m0, beats are not lost, m1 is granted only after m0's final beat.
- TAG_DEPTH=16 reads issued with no returns → 17th read is stalled with waitrequest high, while a concurrent m0 write is granted; one return burst completing frees the slot.
- avl_readdatavalid pulse with empty FIFO → arb_error=1 and stays 1; no mN_readdatavalid; iRST_n low clears it asynchronously.
